ascon_perm_sliced: RTL and testbench



---
 rtl/ascon_perm_sliced_if.sv | 21 ++
 rtl/ascon_perm_sliced.sv | 126 ++++++++++++
 tb/tb_ascon_perm_sliced.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ascon_perm_sliced_if.sv
// Bus between the mode controller and the sliced ASCON permutation.
// Handshake: start is sampled only while the core is idle; done pulses for one cycle with state_out valid.
interface ascon_perm_sliced_if;
  logic         start;
  logic [3:0]   rounds;
  logic [319:0] state_in;
  logic [319:0] state_out;
  logic         busy;
  logic         done;
  logic [1:0]   fsm_state;

  modport master (
    output start, rounds, state_in,
    input  state_out, busy, done, fsm_state
  );

  modport slave (
    input  start, rounds, state_in,
    output state_out, busy, done, fsm_state
  );
endinterface

// File: rtl/ascon_perm_sliced.sv
// Full ASCON permutation p^a/p^b: substitution layer processed SLICE_W columns per cycle,
// linear layer applied over the full width in one cycle.
module ascon_perm_sliced #(
  parameter int SLICE_W    = 1,
  parameter int MAX_ROUNDS = 12
) (
  input logic clk,
  input logic rst,
  ascon_perm_sliced_if.slave bus
);
  localparam logic [6:0]  CNT_LAST = 7'(64 / SLICE_W - 1);
  localparam logic [63:0] LOW_MASK = 64'((65'd1 << SLICE_W) - 65'd1);

  typedef enum logic [1:0] {IDLE = 2'd0, SUB = 2'd1, LIN = 2'd2, DONE = 2'd3} state_t;

  state_t              state, state_nxt;
  logic [63:0]         x [5];
  logic [63:0]         x_sub [5];
  logic [63:0]         x_lin [5];
  logic [63:0]         merged [5];
  logic [SLICE_W-1:0]  s [5];
  logic [SLICE_W-1:0]  b [5];
  logic [SLICE_W-1:0]  y [5];
  logic [SLICE_W-1:0]  rc_bits;
  logic [3:0]          rnd_total, rnd, rc_idx, rounds_clamped;
  logic [6:0]          cnt;
  logic [7:0]          rc;
  logic [319:0]        state_out_q;
  logic                done_q, busy;

  function automatic logic [63:0] ror(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  assign rounds_clamped = (bus.rounds > 4'(MAX_ROUNDS)) ? 4'(MAX_ROUNDS) : bus.rounds;

  // Substitution on the low slice; lanes rotate so the next slice lands at bit 0.
  always_comb begin
    rc_idx  = 4'(MAX_ROUNDS) - rnd_total + rnd;
    rc      = {~rc_idx, rc_idx};
    rc_bits = SLICE_W'(64'(rc) >> (32'(cnt) * SLICE_W));
    s[0] = x[0][SLICE_W-1:0] ^ x[4][SLICE_W-1:0];
    s[1] = x[1][SLICE_W-1:0];
    s[2] = x[2][SLICE_W-1:0] ^ rc_bits ^ x[1][SLICE_W-1:0];
    s[3] = x[3][SLICE_W-1:0];
    s[4] = x[4][SLICE_W-1:0] ^ x[3][SLICE_W-1:0];
    for (int l = 0; l < 5; l++) begin
      b[l] = s[l] ^ (~s[(l + 1) % 5] & s[(l + 2) % 5]);
    end
    y[0] = b[0] ^ b[4];
    y[1] = b[1] ^ b[0];
    y[2] = ~b[2];
    y[3] = b[3] ^ b[2];
    y[4] = b[4];
    for (int l = 0; l < 5; l++) begin
      merged[l] = (x[l] & ~LOW_MASK) | 64'(y[l]);
      x_sub[l]  = ror(merged[l], SLICE_W);
    end
  end

  always_comb begin
    x_lin[0] = x[0] ^ ror(x[0], 19) ^ ror(x[0], 28);
    x_lin[1] = x[1] ^ ror(x[1], 61) ^ ror(x[1], 39);
    x_lin[2] = x[2] ^ ror(x[2], 1)  ^ ror(x[2], 6);
    x_lin[3] = x[3] ^ ror(x[3], 10) ^ ror(x[3], 17);
    x_lin[4] = x[4] ^ ror(x[4], 7)  ^ ror(x[4], 41);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.start) state_nxt = (bus.rounds == 4'd0) ? DONE : SUB;
      SUB:  if (cnt == CNT_LAST) state_nxt = LIN;
      LIN:  state_nxt = (rnd + 4'd1 == rnd_total) ? DONE : SUB;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == SUB) || (state == LIN);
  end

  // The bypass (rounds=0) also loads the lanes, so DONE always publishes from them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int l = 0; l < 5; l++) x[l] <= '0;
      rnd_total   <= '0;
      rnd         <= '0;
      cnt         <= '0;
      state_out_q <= '0;
      done_q      <= 1'b0;
    end else begin
      done_q <= (state == DONE);
      case (state)
        IDLE: if (bus.start) begin
          for (int l = 0; l < 5; l++) x[l] <= bus.state_in[319 - 64 * l -: 64];
          rnd_total <= rounds_clamped;
          rnd       <= '0;
          cnt       <= '0;
        end
        SUB: begin
          for (int l = 0; l < 5; l++) x[l] <= x_sub[l];
          cnt <= (cnt == CNT_LAST) ? 7'd0 : cnt + 7'd1;
        end
        LIN: begin
          for (int l = 0; l < 5; l++) x[l] <= x_lin[l];
          rnd <= rnd + 4'd1;
          cnt <= '0;
        end
        DONE: state_out_q <= {x[0], x[1], x[2], x[3], x[4]};
        default: ;
      endcase
    end
  end

  assign bus.state_out = state_out_q;
  assign bus.done      = done_q;
  assign bus.busy      = busy;
  assign bus.fsm_state = state;
endmodule

// File: tb/tb_ascon_perm_sliced.sv
// Bench for ascon_perm_sliced: four instances (SLICE_W 1, 4, 8, 64) checked against a
// table-driven ASCON permutation model.
module tb_ascon_perm_sliced;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  int slice_w [4] = '{1, 4, 8, 64};

  logic         start_d [4];
  logic [3:0]   rounds_d [4];
  logic [319:0] state_in_d [4];
  logic         busy_o [4];
  logic         done_o [4];
  logic [319:0] state_out_o [4];

  ascon_perm_sliced_if ifc0 ();
  ascon_perm_sliced_if ifc1 ();
  ascon_perm_sliced_if ifc2 ();
  ascon_perm_sliced_if ifc3 ();

  ascon_perm_sliced #(.SLICE_W(1))  dut0 (.clk(clk), .rst(rst), .bus(ifc0.slave));
  ascon_perm_sliced #(.SLICE_W(4))  dut1 (.clk(clk), .rst(rst), .bus(ifc1.slave));
  ascon_perm_sliced #(.SLICE_W(8))  dut2 (.clk(clk), .rst(rst), .bus(ifc2.slave));
  ascon_perm_sliced #(.SLICE_W(64)) dut3 (.clk(clk), .rst(rst), .bus(ifc3.slave));

  assign ifc0.start = start_d[0]; assign ifc0.rounds = rounds_d[0]; assign ifc0.state_in = state_in_d[0];
  assign ifc1.start = start_d[1]; assign ifc1.rounds = rounds_d[1]; assign ifc1.state_in = state_in_d[1];
  assign ifc2.start = start_d[2]; assign ifc2.rounds = rounds_d[2]; assign ifc2.state_in = state_in_d[2];
  assign ifc3.start = start_d[3]; assign ifc3.rounds = rounds_d[3]; assign ifc3.state_in = state_in_d[3];
  assign busy_o[0] = ifc0.busy; assign done_o[0] = ifc0.done; assign state_out_o[0] = ifc0.state_out;
  assign busy_o[1] = ifc1.busy; assign done_o[1] = ifc1.done; assign state_out_o[1] = ifc1.state_out;
  assign busy_o[2] = ifc2.busy; assign done_o[2] = ifc2.done; assign state_out_o[2] = ifc2.state_out;
  assign busy_o[3] = ifc3.busy; assign done_o[3] = ifc3.done; assign state_out_o[3] = ifc3.state_out;

  // ---------------- reference model ----------------
  logic [4:0] sbox_tab [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

  function automatic logic [63:0] rot(input logic [63:0] v, input int n);
    logic [127:0] t;
    t = {v, v} >> n;
    return t[63:0];
  endfunction

  function automatic logic [319:0] ref_perm(input logic [319:0] st, input int nr);
    logic [63:0] x [5];
    logic [4:0]  col, o;
    int          n, idx;
    n = (nr > 12) ? 12 : nr;
    for (int l = 0; l < 5; l++) x[l] = st[319 - 64 * l -: 64];
    for (int r = 0; r < n; r++) begin
      idx  = 12 - n + r;
      x[2] = x[2] ^ 64'(((15 - idx) << 4) | idx);
      for (int bt = 0; bt < 64; bt++) begin
        col = {x[0][bt], x[1][bt], x[2][bt], x[3][bt], x[4][bt]};
        o   = sbox_tab[col];
        x[0][bt] = o[4]; x[1][bt] = o[3]; x[2][bt] = o[2]; x[3][bt] = o[1]; x[4][bt] = o[0];
      end
      x[0] = x[0] ^ rot(x[0], 19) ^ rot(x[0], 28);
      x[1] = x[1] ^ rot(x[1], 61) ^ rot(x[1], 39);
      x[2] = x[2] ^ rot(x[2], 1)  ^ rot(x[2], 6);
      x[3] = x[3] ^ rot(x[3], 10) ^ rot(x[3], 17);
      x[4] = x[4] ^ rot(x[4], 7)  ^ rot(x[4], 41);
    end
    return {x[0], x[1], x[2], x[3], x[4]};
  endfunction

  function automatic int lat_of(input int k, input int nr);
    int n;
    n = (nr > 12) ? 12 : nr;
    if (n == 0) return 1;
    return n * (64 / slice_w[k] + 1) + 1;
  endfunction

  function automatic logic [319:0] rand320();
    logic [319:0] v;
    for (int i = 0; i < 10; i++) v[32 * i +: 32] = $urandom;
    return v;
  endfunction

  // ---------------- driver ----------------
  // Returns the number of clock edges from the accepting edge to the done pulse, or -1 on timeout.
  task automatic run_perm(input int k, input logic [3:0] rn, input logic [319:0] si,
                          output int lat, output logic [319:0] so);
    bit seen;
    @(negedge clk);
    rounds_d[k] = rn; state_in_d[k] = si; start_d[k] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_d[k] = 1'b0;
    lat = 0; seen = 0;
    while (!seen && lat < 2000) begin
      @(posedge clk); lat++; #1;
      if (done_o[k]) seen = 1;
    end
    if (!seen) lat = -1;
    so = state_out_o[k];
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int lat; logic [319:0] s, so, ref_v; bit seen;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_checks++; if (busy_o[k] !== 1'b0) begin n_fail++; $display("FAIL reset_busy[%0d]: got %b expected 0", k, busy_o[k]); end
      n_checks++; if (done_o[k] !== 1'b0) begin n_fail++; $display("FAIL reset_done[%0d]: got %b expected 0", k, done_o[k]); end
      n_checks++; if (state_out_o[k] !== 320'd0) begin n_fail++; $display("FAIL reset_state_out[%0d]: got %h expected 0", k, state_out_o[k]); end
    end
    s = rand320(); ref_v = ref_perm(s, 2);
    run_perm(1, 4'd2, s, lat, so);
    n_checks++; if (so !== ref_v) begin n_fail++; $display("FAIL pre_reset_result: got %h expected %h", so, ref_v); end
    @(negedge clk);
    rounds_d[1] = 4'd6; state_in_d[1] = rand320(); start_d[1] = 1'b1;
    @(negedge clk); start_d[1] = 1'b0;
    repeat (5) @(negedge clk);
    n_checks++; if (busy_o[1] !== 1'b1) begin n_fail++; $display("FAIL mid_run_busy: got %b expected 1", busy_o[1]); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if (busy_o[1] !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b expected 0", busy_o[1]); end
    n_checks++; if (done_o[1] !== 1'b0) begin n_fail++; $display("FAIL abort_done: got %b expected 0", done_o[1]); end
    n_checks++; if (state_out_o[1] !== 320'd0) begin n_fail++; $display("FAIL abort_state_out: got %h expected 0", state_out_o[1]); end
    @(negedge clk); rst = 1'b0;
    seen = 0;
    repeat (300) begin @(posedge clk); #1; if (done_o[1]) seen = 1; end
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL abort_no_done: got %b expected 0", seen); end
  endtask

  task automatic test_single_round();
    int lat; logic [319:0] so, ref_v;
    ref_v = ref_perm(320'd0, 1);
    run_perm(0, 4'd1, 320'd0, lat, so);
    n_checks++; if (lat !== 66) begin n_fail++; $display("FAIL single_round_latency: got %0d expected 66", lat); end
    n_checks++; if (so !== ref_v) begin n_fail++; $display("FAIL single_round_state: got %h expected %h", so, ref_v); end
  endtask

  task automatic test_width_sweep();
    int lat; logic [319:0] s, so, ref_v;
    s = rand320(); ref_v = ref_perm(s, 12);
    for (int k = 0; k < 4; k++) begin
      run_perm(k, 4'd12, s, lat, so);
      n_checks++; if (lat !== lat_of(k, 12)) begin n_fail++; $display("FAIL sweep_latency[w=%0d]: got %0d expected %0d", slice_w[k], lat, lat_of(k, 12)); end
      n_checks++; if (so !== ref_v) begin n_fail++; $display("FAIL sweep_state[w=%0d]: got %h expected %h", slice_w[k], so, ref_v); end
    end
  endtask

  task automatic test_pb();
    int lat; logic [319:0] s, so, ref_v;
    s = rand320(); ref_v = ref_perm(s, 6);
    run_perm(2, 4'd6, s, lat, so);
    n_checks++; if (lat !== 55) begin n_fail++; $display("FAIL pb_latency: got %0d expected 55", lat); end
    n_checks++; if (so !== ref_v) begin n_fail++; $display("FAIL pb_state: got %h expected %h", so, ref_v); end
  endtask

  task automatic test_boundary();
    int lat; logic [319:0] s, so, ref_v;
    s = rand320();
    run_perm(2, 4'd0, s, lat, so);
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL bypass_latency: got %0d expected 1", lat); end
    n_checks++; if (so !== s) begin n_fail++; $display("FAIL bypass_state: got %h expected %h", so, s); end
    ref_v = ref_perm(s, 12);
    run_perm(2, 4'd15, s, lat, so);
    n_checks++; if (lat !== 109) begin n_fail++; $display("FAIL clamp15_latency: got %0d expected 109", lat); end
    n_checks++; if (so !== ref_v) begin n_fail++; $display("FAIL clamp15_state: got %h expected %h", so, ref_v); end
    run_perm(3, 4'd13, s, lat, so);
    n_checks++; if (lat !== 25) begin n_fail++; $display("FAIL clamp13_latency: got %0d expected 25", lat); end
    n_checks++; if (so !== ref_v) begin n_fail++; $display("FAIL clamp13_state: got %h expected %h", so, ref_v); end
  endtask

  task automatic test_random();
    int lat, k, rn; logic [319:0] s, so, ref_v;
    for (int it = 0; it < 8; it++) begin
      k  = $urandom_range(1, 3);
      rn = $urandom_range(0, 15);
      s  = rand320(); ref_v = ref_perm(s, rn);
      run_perm(k, 4'(rn), s, lat, so);
      n_checks++; if (lat !== lat_of(k, rn)) begin n_fail++; $display("FAIL random_latency[w=%0d r=%0d]: got %0d expected %0d", slice_w[k], rn, lat, lat_of(k, rn)); end
      n_checks++; if (so !== ref_v) begin n_fail++; $display("FAIL random_state[w=%0d r=%0d]: got %h expected %h", slice_w[k], rn, so, ref_v); end
    end
  endtask

  task automatic test_busy_start();
    int lat, first_lat, dones, busy_low; logic [319:0] s, so, ref_v;
    s = rand320(); ref_v = ref_perm(s, 3);
    @(negedge clk);
    rounds_d[2] = 4'd3; state_in_d[2] = s; start_d[2] = 1'b1;
    @(posedge clk);
    @(negedge clk); start_d[2] = 1'b0;
    lat = 0; first_lat = -1; dones = 0; busy_low = 0; so = '0;
    repeat (28 + 40) begin
      @(posedge clk); lat++; #1;
      if (lat == 4) begin start_d[2] = 1'b1; rounds_d[2] = 4'd1; state_in_d[2] = rand320(); end
      if (lat == 6) start_d[2] = 1'b0;
      if (done_o[2]) begin
        dones++;
        if (first_lat < 0) begin first_lat = lat; so = state_out_o[2]; end
      end
      if (lat <= 26 && !busy_o[2]) busy_low++;
    end
    n_checks++; if (dones !== 1) begin n_fail++; $display("FAIL busy_start_done_count: got %0d expected 1", dones); end
    n_checks++; if (first_lat !== 28) begin n_fail++; $display("FAIL busy_start_latency: got %0d expected 28", first_lat); end
    n_checks++; if (busy_low !== 0) begin n_fail++; $display("FAIL busy_start_busy_drop: got %0d low cycles expected 0", busy_low); end
    n_checks++; if (so !== ref_v) begin n_fail++; $display("FAIL busy_start_state: got %h expected %h", so, ref_v); end
  endtask

  task automatic test_back_to_back();
    int lat1, lat2; logic [319:0] s1, s2, so1, so2, r1, r2; bit seen;
    s1 = rand320(); s2 = rand320();
    r1 = ref_perm(s1, 2); r2 = ref_perm(s2, 5);
    run_perm(3, 4'd2, s1, lat1, so1);
    start_d[3] = 1'b1; rounds_d[3] = 4'd5; state_in_d[3] = s2;
    @(posedge clk); #1 start_d[3] = 1'b0;
    lat2 = 0; seen = 0;
    while (!seen && lat2 < 200) begin
      @(posedge clk); lat2++; #1;
      if (done_o[3]) seen = 1;
    end
    if (!seen) lat2 = -1;
    so2 = state_out_o[3];
    n_checks++; if (lat1 !== 5) begin n_fail++; $display("FAIL b2b_first_latency: got %0d expected 5", lat1); end
    n_checks++; if (so1 !== r1) begin n_fail++; $display("FAIL b2b_first_state: got %h expected %h", so1, r1); end
    n_checks++; if (lat2 !== 11) begin n_fail++; $display("FAIL b2b_second_latency: got %0d expected 11", lat2); end
    n_checks++; if (so2 !== r2) begin n_fail++; $display("FAIL b2b_second_state: got %h expected %h", so2, r2); end
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      start_d[k] = 1'b0; rounds_d[k] = 4'd0; state_in_d[k] = '0;
    end
    test_reset();
    test_single_round();
    test_width_sweep();
    test_pb();
    test_boundary();
    test_random();
    test_busy_start();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
